// File: rtl/mem_sram_ctrl.sv
// MEM-stage data memory initiator: splits one 32-bit word access into two
// registered 16-bit SRAM half-word accesses with a programmable hold time.
//
// state | meaning
// IDLE  | waiting for memRead/memWrite; ready=1 only when no request is present
// LOW   | half-word {idx,0}, bits 15:0, held WAIT_CYCLES cycles
// HIGH  | half-word {idx,1}, bits 31:16, held WAIT_CYCLES cycles
// DONE  | one-cycle completion, ready=1, readData valid
module mem_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [31:0]       address,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              ready,
  output logic [ADDR_W-1:0] sramAddr,
  output logic [15:0]       sramDqOut,
  input  logic [15:0]       sramDqIn,
  output logic              sramDqOe,
  output logic              sramWeN
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic              tc;
  logic              req;
  logic [31:0]       offset;
  logic [ADDR_W-2:0] idx_in;
  logic [ADDR_W-2:0] idx_q;
  logic [15:0]       wdata_hi;
  logic              is_wr;
  logic              unused_offset;

  // A request is not seen while reset is held, so ready stays 1 until rst rises.
  assign req           = rst & (memRead | memWrite);
  assign offset        = address - 32'(BASE_ADDR);
  assign idx_in        = offset[ADDR_W:2];
  assign unused_offset = ^offset;
  assign tc            = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if ((state_n == LOW || state_n == HIGH) && state_n != state)
        cnt <= RELOAD;
      else if (!tc)
        cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req) state_n = LOW;
      LOW:     if (tc) state_n = HIGH;
      HIGH:    if (tc) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // SRAM pins only change on phase-entry edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      readData  <= '0;
      sramAddr  <= '0;
      sramDqOut <= '0;
      sramWeN   <= 1'b1;
      sramDqOe  <= 1'b0;
      is_wr     <= 1'b0;
      idx_q     <= '0;
      wdata_hi  <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          is_wr    <= memWrite;
          idx_q    <= idx_in;
          wdata_hi <= writeData[31:16];
          sramAddr <= {idx_in, 1'b0};
          sramWeN  <= ~memWrite;
          sramDqOe <= memWrite;
          if (memWrite) sramDqOut <= writeData[15:0];
        end
        LOW: if (tc) begin
          if (!is_wr) readData[15:0] <= sramDqIn;
          if (is_wr) sramDqOut <= wdata_hi;
          sramAddr <= {idx_q, 1'b1};
        end
        HIGH: if (tc) begin
          if (!is_wr) readData[31:16] <= sramDqIn;
          sramWeN  <= 1'b1;
          sramDqOe <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: W=2 instance for most scenarios, W=1
// instance for back-to-back reads; a behavioural SRAM backs both.
module tb_mem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite;
  logic [31:0] address, writeData, readData;
  logic        ready, sramDqOe, sramWeN;
  logic [17:0] sramAddr;
  logic [15:0] sramDqOut, sramDqIn;

  logic        memRead2, memWrite2;
  logic [31:0] address2, writeData2, readData2;
  logic        ready2, sramDqOe2, sramWeN2;
  logic [17:0] sramAddr2;
  logic [15:0] sramDqOut2, sramDqIn2;

  bit [15:0] mem [0:262143];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_sram_ctrl dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .address(address), .writeData(writeData), .readData(readData),
    .ready(ready), .sramAddr(sramAddr), .sramDqOut(sramDqOut),
    .sramDqIn(sramDqIn), .sramDqOe(sramDqOe), .sramWeN(sramWeN)
  );

  mem_sram_ctrl #(.WAIT_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .memRead(memRead2), .memWrite(memWrite2),
    .address(address2), .writeData(writeData2), .readData(readData2),
    .ready(ready2), .sramAddr(sramAddr2), .sramDqOut(sramDqOut2),
    .sramDqIn(sramDqIn2), .sramDqOe(sramDqOe2), .sramWeN(sramWeN2)
  );

  // SRAM model; a few locations are preloaded while reset is low.
  always @(posedge clk) begin
    if (!rst) begin
      mem[0]       <= 16'h1111;
      mem[1]       <= 16'h2222;
      mem[18'h3FFFE] <= 16'hA5A5;
      mem[18'h3FFFF] <= 16'h5A5A;
    end else if (!sramWeN) begin
      mem[sramAddr] <= sramDqOut;
    end
  end
  assign sramDqIn  = mem[sramAddr];
  assign sramDqIn2 = mem[sramAddr2];

  task automatic test_reset();
    rst = 1'b0; memWrite = 1'b1; memRead = 1'b0; address = 32'd1028;
    writeData = 32'hFFFF_FFFF;
    memRead2 = 1'b0; memWrite2 = 1'b0; address2 = 32'd0; writeData2 = 32'd0;
    repeat (2) @(negedge clk);
    n_cmp++; if (sramWeN !== 1'b1) begin n_err++; $display("FAIL reset_wen: got %b want 1", sramWeN); end
    n_cmp++; if (sramDqOe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", sramDqOe); end
    n_cmp++; if (readData !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", readData); end
    n_cmp++; if (sramAddr !== 18'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", sramAddr); end
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_in_rst: got %b want 1", ready); end
    n_cmp++; if (readData2 !== 32'd0) begin n_err++; $display("FAIL reset_rdata2: got %h want 0", readData2); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_after_rst: got %b want 0", ready); end
    memWrite = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_idle: got %b want 1", ready); end
    @(negedge clk);
    n_cmp++; if (sramWeN !== 1'b1 || ready !== 1'b1) begin
      n_err++; $display("FAIL reset_stays_idle: got wen=%b ready=%b want 1 1", sramWeN, ready);
    end
  endtask

  task automatic test_write_read();
    logic [17:0] ea;
    logic [15:0] ed;
    // write 0xDEADBEEF at 1028 -> idx 1 -> half-words 2 and 3
    memWrite = 1'b1; address = 32'd1028; writeData = 32'hDEADBEEF;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL wr_ready_c0: got %b want 0", ready); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        ea = (c <= 2) ? 18'd2 : 18'd3;
        ed = (c <= 2) ? 16'hBEEF : 16'hDEAD;
        n_cmp++; if (sramAddr !== ea || sramDqOut !== ed || sramWeN !== 1'b0 || sramDqOe !== 1'b1 || ready !== 1'b0) begin
          n_err++; $display("FAIL wr_cycle%0d: got addr=%h dq=%h wen=%b oe=%b rdy=%b want addr=%h dq=%h wen=0 oe=1 rdy=0",
                            c, sramAddr, sramDqOut, sramWeN, sramDqOe, ready, ea, ed);
        end
        if (c == 1) begin address = 32'd0; writeData = 32'h0; end
      end else begin
        n_cmp++; if (ready !== 1'b1 || sramWeN !== 1'b1 || sramDqOe !== 1'b0) begin
          n_err++; $display("FAIL wr_done: got rdy=%b wen=%b oe=%b want 1 1 0", ready, sramWeN, sramDqOe);
        end
      end
    end
    memWrite = 1'b0;
    @(negedge clk);
    memRead = 1'b1; address = 32'd1028;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        ea = (c <= 2) ? 18'd2 : 18'd3;
        n_cmp++; if (sramAddr !== ea || sramWeN !== 1'b1 || sramDqOe !== 1'b0 || ready !== 1'b0) begin
          n_err++; $display("FAIL rd_cycle%0d: got addr=%h wen=%b oe=%b rdy=%b want addr=%h wen=1 oe=0 rdy=0",
                            c, sramAddr, sramWeN, sramDqOe, ready, ea);
        end
      end else begin
        n_cmp++; if (ready !== 1'b1 || readData !== 32'hDEADBEEF) begin
          n_err++; $display("FAIL rd_done: got rdy=%b data=%h want 1 deadbeef", ready, readData);
        end
      end
    end
    memRead = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [17:0] ea;
    logic [15:0] ed;
    memRead = 1'b1; memWrite = 1'b1; address = 32'd1032; writeData = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        ea = (c <= 2) ? 18'd4 : 18'd5;
        ed = (c <= 2) ? 16'h5678 : 16'h1234;
        n_cmp++; if (sramAddr !== ea || sramDqOut !== ed || sramWeN !== 1'b0) begin
          n_err++; $display("FAIL both_cycle%0d: got addr=%h dq=%h wen=%b want addr=%h dq=%h wen=0",
                            c, sramAddr, sramDqOut, sramWeN, ea, ed);
        end
      end else begin
        n_cmp++; if (ready !== 1'b1 || readData !== 32'hDEADBEEF) begin
          n_err++; $display("FAIL both_done: got rdy=%b data=%h want 1 deadbeef", ready, readData);
        end
      end
    end
    memRead = 1'b0; memWrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [17:0] ea;
    memRead = 1'b1; address = 32'd1020;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        ea = (c <= 2) ? 18'h3FFFE : 18'h3FFFF;
        n_cmp++; if (sramAddr !== ea) begin
          n_err++; $display("FAIL wrap_cycle%0d: got addr=%h want %h", c, sramAddr, ea);
        end
      end else begin
        n_cmp++; if (ready !== 1'b1 || readData !== 32'h5A5AA5A5) begin
          n_err++; $display("FAIL wrap_done: got rdy=%b data=%h want 1 5a5aa5a5", ready, readData);
        end
      end
    end
    memRead = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    memWrite = 1'b1; address = 32'd1036; writeData = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    n_cmp++; if (sramAddr !== 18'd7 || sramDqOut !== 16'hCAFE || sramWeN !== 1'b0) begin
      n_err++; $display("FAIL mid_high: got addr=%h dq=%h wen=%b want 7 cafe 0", sramAddr, sramDqOut, sramWeN);
    end
    rst = 1'b0; memWrite = 1'b0;
    @(negedge clk);
    n_cmp++; if (sramWeN !== 1'b1 || sramDqOe !== 1'b0 || sramAddr !== 18'd0 || readData !== 32'd0 || ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset: got wen=%b oe=%b addr=%h data=%h rdy=%b want 1 0 0 0 1",
                        sramWeN, sramDqOe, sramAddr, readData, ready);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_release_ready: got %b want 1", ready); end
    @(negedge clk);
    n_cmp++; if (sramWeN !== 1'b1 || ready !== 1'b1) begin
      n_err++; $display("FAIL mid_idle: got wen=%b rdy=%b want 1 1", sramWeN, ready);
    end
  endtask

  task automatic test_back_to_back();
    logic       er;
    logic [17:0] ea;
    memRead2 = 1'b1; address2 = 32'd1024;
    #1;
    n_cmp++; if (ready2 !== 1'b0) begin n_err++; $display("FAIL b2b_ready_c0: got %b want 0", ready2); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      er = (c == 3 || c == 7 || c == 8);
      n_cmp++; if (ready2 !== er) begin
        n_err++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, ready2, er);
      end
      if (c >= 4 && c <= 6) begin
        ea = (c == 4) ? 18'd1 : (c == 5) ? 18'd2 : 18'd3;
        n_cmp++; if (sramAddr2 !== ea) begin
          n_err++; $display("FAIL b2b_addr_c%0d: got %h want %h", c, sramAddr2, ea);
        end
      end
      if (c == 3) begin
        n_cmp++; if (readData2 !== 32'h22221111) begin
          n_err++; $display("FAIL b2b_data1: got %h want 22221111", readData2);
        end
      end
      if (c == 7) begin
        n_cmp++; if (readData2 !== 32'hDEADBEEF) begin
          n_err++; $display("FAIL b2b_data2: got %h want deadbeef", readData2);
        end
        memRead2 = 1'b0;
      end
      if (c == 4) address2 = 32'd1028;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_wrap();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Pipeline-side initiator for data memory, placed in the MEM stage between the EX/MEM register and an external 16-bit SRAM. It turns a single-cycle memRead/memWrite request on a 32-bit byte address into two sequenced half-word SRAM accesses with programmable wait states. It deasserts ready to freeze the pipeline until the word transfer completes.

## Interface
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles each half-word access is held on the SRAM bus; must be 1 or more.
- ADDR_W, 18: SRAM half-word address width.

- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset.
- memRead  input  1  word read request; held stable by the pipeline while ready=0.
- memWrite  input  1  word write request; held stable while ready=0.
- address  input  32  byte address of the access.
- writeData  input  32  store data.
- readData  output  32  loaded word; valid in the DONE cycle and held until the next read completes.
- ready  output  1  0 freezes the pipeline.
- sramAddr  output  ADDR_W  half-word address.
- sramDqOut  output  16  write data toward the SRAM.
- sramDqIn  input  16  read data from the SRAM.
- sramDqOe  output  1  1 = controller drives the data bus.
- sramWeN  output  1  active-low write enable.

## Operation
- The word index is (address - BASE_ADDR) >> 2, computed with 32-bit modulo arithmetic and truncated to ADDR_W-1 bits. Addresses below BASE_ADDR wrap; no error is flagged.
- The low half uses sramAddr = {idx, 0} and carries bits 15:0. The high half uses sramAddr = {idx, 1} and carries bits 31:16.
- If memRead and memWrite are both 1, the access is a write.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE to LOW: when memRead or memWrite is 1. The op type, index and writeData are latched.
  - LOW to HIGH: after WAIT_CYCLES cycles, counted by an internal wait counter that reloads on every phase entry.
  - HIGH to DONE: after WAIT_CYCLES cycles.
  - DONE to IDLE: unconditionally. Any request present in the DONE cycle is ignored, because the pipeline advances at that edge.
- Reads:
  - sramDqIn is captured into readData[15:0] on the last LOW cycle and into readData[31:16] on the last HIGH cycle.
  - sramWeN=1 and sramDqOe=0 throughout.
- Writes:
  - sramWeN=0 and sramDqOe=1 for every LOW/HIGH cycle.
  - sramDqOut carries the latched half-word for the current phase.
  - readData is unchanged.
- ready is combinational:
  - 1 in DONE.
  - 1 in IDLE when there is no request.
  - 0 otherwise, including the IDLE cycle in which a request first appears.
- In IDLE and DONE: sramWeN=1, sramDqOe=0, sramAddr holds its last value.
- Changes to address or writeData after the request has been latched do not affect the access in progress.

## Timing
- Reset values (when rst=0 at an edge):
  - state IDLE, wait counter 0.
  - readData 0, sramAddr 0, sramDqOut 0, sramWeN 1, sramDqOe 0.
  - ready follows its IDLE rule.
- Reset mid-access aborts the access at that edge. A write can leave the SRAM half-written; this is accepted.
- Latency, with the request seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W and HIGH occupies cycles W+1..2W, where W = WAIT_CYCLES.
  - DONE is cycle 2W+1, with ready=1 and readData valid.
  - The pipeline is frozen for 2W+1 cycles.
- Back-to-back requests: the next request is accepted in the IDLE cycle that follows DONE, so there is a 1-cycle gap between accesses.
- Outputs sramAddr, sramDqOut, sramWeN and sramDqOe are registered. They change only on the phase-entry edge, which gives a glitch-free SRAM interface.

## Test plan
- Reset: hold rst=0 for 2 cycles with memWrite=1 -> sramWeN=1, sramDqOe=0, readData=0, state IDLE; ready=0 only after rst rises.
- Write then read, W=2: write 0xDEADBEEF to address 1028 -> sramAddr=2 with sramDqOut=0xBEEF for 2 cycles, then sramAddr=3 with 0xDEAD for 2 cycles. ready=1 at cycle 5. A following read of 1028 returns 0xDEADBEEF at its cycle 5.
- Simultaneous memRead=memWrite=1 at 1032 with writeData 0x12345678 -> treated as a write (sramWeN=0 at sramAddr 4 and 5); readData unchanged.
- Wrap: read at address 1020 -> idx = 0x3FFFFFFF truncated to 17 bits = 0x1FFFF, so sramAddr 0x3FFFE then 0x3FFFF.
- Reset mid-access: assert rst=0 during the HIGH phase of a write -> next cycle IDLE, sramWeN=1, ready follows its IDLE rule.
- WAIT_CYCLES=1 back-to-back reads at 1024 and 1028 -> ready pulses at cycles 3 and 7; the request held during the first DONE is not reissued.
